// File: rtl/clock_edge_monitor.sv
// clock_edge_monitor
// Brings a slow, asynchronous square wave (typically a divided clock) into the
// i_clk domain, turns its edges into single-cycle rise/fall strobes, measures
// the number of i_clk cycles between consecutive edges and flags an input that
// has stopped toggling. Downstream logic should use o_rise/o_fall as clock
// enables rather than clocking anything from i_tick_clk itself.
//
// Behaviour summary:
//   - i_tick_clk -> s1 -> s2 -> s3; s1/s2 resolve metastability, s3 is history.
//   - A change sampled at i_clk edge k shows up on o_rise/o_fall after edge k+2.
//   - cnt restarts at 1 on every edge and saturates at TIMEOUT.
//   - The first edge after reset or after a stall only arms the measurement;
//     every later edge captures cnt into o_half_period.
//   - An edge in the same cycle that cnt reaches TIMEOUT still captures.
//   - Reaching TIMEOUT without an edge reports a stall and drops the
//     measurement, regardless of whether the block was ever armed.
// No valid/ready handshakes: all outputs are free-running registered levels
// or single-cycle strobes.

module clock_edge_monitor #(
  parameter int                   COUNT_WIDTH = 24,
  parameter logic [COUNT_WIDTH:0] TIMEOUT     = (COUNT_WIDTH+1)'(12_000_000)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick_clk,
  output logic                   o_rise,
  output logic                   o_fall,
  output logic [COUNT_WIDTH:0]   o_half_period,
  output logic                   o_period_valid,
  output logic                   o_stalled
);

  logic                 s1;
  logic                 s2;
  logic                 s3;
  logic [COUNT_WIDTH:0] cnt;
  logic                 armed;

  logic                 rise_e;
  logic                 fall_e;
  logic                 edge_e;
  logic                 at_timeout;

  // Edge events derived from the synchronized level and its one-cycle history.
  always_comb begin
    rise_e     = s2 & ~s3;
    fall_e     = ~s2 & s3;
    edge_e     = rise_e | fall_e;
    at_timeout = (cnt == TIMEOUT);
  end

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_tick_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Registered single-cycle strobes; rise_e and fall_e are mutually exclusive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= rise_e;
      o_fall <= fall_e;
    end
  end

  // Interval counter: restarts at 1 on an edge, saturates at TIMEOUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (edge_e) begin
      cnt <= (COUNT_WIDTH+1)'(1);
    end else if (!at_timeout) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Arming, capture and stall tracking; an edge always takes priority over
  // the timeout so an interval of exactly TIMEOUT is still a valid capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed          <= 1'b0;
      o_half_period  <= '0;
      o_period_valid <= 1'b0;
      o_stalled      <= 1'b0;
    end else if (edge_e) begin
      armed     <= 1'b1;
      o_stalled <= 1'b0;
      if (armed && !o_stalled) begin
        o_half_period  <= cnt;
        o_period_valid <= 1'b1;
      end
    end else if (at_timeout) begin
      armed          <= 1'b0;
      o_stalled      <= 1'b1;
      o_period_valid <= 1'b0;
      o_half_period  <= '0;
    end
  end

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Directed testbench for clock_edge_monitor with TIMEOUT = 20.
// Inputs are driven 1 ns after each rising i_clk edge and outputs are sampled
// at the same point, so a level driven in loop iteration j is captured by the
// rising edge of iteration j and its strobe is visible after the edge of
// iteration j+2.

module tb_clock_edge_monitor;

  localparam int CW = 24;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_tick_clk;
  logic          o_rise;
  logic          o_fall;
  logic [CW:0]   o_half_period;
  logic          o_period_valid;
  logic          o_stalled;
  logic [CW+4:0] outs;

  int checks;
  int errors;

  clock_edge_monitor #(
    .COUNT_WIDTH (CW),
    .TIMEOUT     ((CW+1)'(20))
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_tick_clk     (i_tick_clk),
    .o_rise         (o_rise),
    .o_fall         (o_fall),
    .o_half_period  (o_half_period),
    .o_period_valid (o_period_valid),
    .o_stalled      (o_stalled)
  );

  assign outs = {o_rise, o_fall, o_half_period, o_period_valid, o_stalled};

  // Clock generation
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n    = 1'b0;
    i_tick_clk = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  // Reset holds everything at 0; a dead input after release reports stalled.
  task automatic test_reset();
    i_rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_tick_clk = i[0];
      step();
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, outs);
      end
    end
    i_tick_clk = 1'b0;
    i_rst_n    = 1'b1;
    for (int j = 0; j < 25; j++) begin
      step();
      checks++;
      if (o_rise !== 1'b0 || o_fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_strobe j=%0d got rise=%b fall=%b exp 0 0", j, o_rise, o_fall);
      end
      checks++;
      if (o_stalled !== (j >= 20) || o_period_valid !== 1'b0 || o_half_period !== '0) begin
        errors++;
        $display("FAIL reset_dead_stall j=%0d got stalled=%b valid=%b hp=%0d exp stalled=%b valid=0 hp=0",
                 j, o_stalled, o_period_valid, o_half_period, (j >= 20));
      end
    end
  endtask

  // 5 high / 5 low: rises at j=2+10n, falls at j=7+10n, every capture is 5.
  task automatic test_symmetric();
    logic exp_r;
    logic exp_f;
    do_reset();
    for (int j = 0; j < 60; j++) begin
      i_tick_clk = ((j / 5) % 2 == 0);
      step();
      exp_r = (j >= 2) && ((j - 2) % 10 == 0);
      exp_f = (j >= 7) && ((j - 7) % 10 == 0);
      checks++;
      if (o_rise !== exp_r || o_fall !== exp_f || o_stalled !== 1'b0) begin
        errors++;
        $display("FAIL sym_strobe j=%0d got rise=%b fall=%b stalled=%b exp rise=%b fall=%b stalled=0",
                 j, o_rise, o_fall, o_stalled, exp_r, exp_f);
      end
      if (j < 7) begin
        checks++;
        if (o_period_valid !== 1'b0) begin
          errors++;
          $display("FAIL sym_valid_early j=%0d got=%b exp=0", j, o_period_valid);
        end
      end else if (exp_r || exp_f) begin
        checks++;
        if (o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(5)) begin
          errors++;
          $display("FAIL sym_period j=%0d got valid=%b hp=%0d exp valid=1 hp=5", j, o_period_valid, o_half_period);
        end
      end
    end
  endtask

  // 3 high / 7 low: captures alternate 3 (at falls) and 7 (at rises).
  task automatic test_asymmetric();
    logic exp_r;
    logic exp_f;
    do_reset();
    for (int j = 0; j < 50; j++) begin
      i_tick_clk = ((j % 10) < 3);
      step();
      exp_r = (j >= 2) && ((j - 2) % 10 == 0);
      exp_f = (j >= 5) && ((j - 5) % 10 == 0);
      checks++;
      if (o_rise !== exp_r || o_fall !== exp_f || (o_rise & o_fall) !== 1'b0) begin
        errors++;
        $display("FAIL asym_strobe j=%0d got rise=%b fall=%b exp rise=%b fall=%b", j, o_rise, o_fall, exp_r, exp_f);
      end
      if (exp_f) begin
        checks++;
        if (o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(3)) begin
          errors++;
          $display("FAIL asym_fall_period j=%0d got valid=%b hp=%0d exp valid=1 hp=3", j, o_period_valid, o_half_period);
        end
      end
      if (exp_r && j >= 12) begin
        checks++;
        if (o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(7)) begin
          errors++;
          $display("FAIL asym_rise_period j=%0d got valid=%b hp=%0d exp valid=1 hp=7", j, o_period_valid, o_half_period);
        end
      end
    end
  endtask

  // Last strobe at j=27, stall at j=47, wave resumes at j=50.
  task automatic test_stall();
    do_reset();
    for (int j = 0; j < 70; j++) begin
      if (j < 30)      i_tick_clk = ((j / 5) % 2 == 0);
      else if (j < 50) i_tick_clk = 1'b0;
      else             i_tick_clk = (((j - 50) / 5) % 2 == 0);
      step();
      if (j == 27 || j == 46) begin
        checks++;
        if (o_stalled !== 1'b0 || o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(5)) begin
          errors++;
          $display("FAIL stall_before j=%0d got stalled=%b valid=%b hp=%0d exp stalled=0 valid=1 hp=5",
                   j, o_stalled, o_period_valid, o_half_period);
        end
      end
      if (j >= 47 && j <= 51) begin
        checks++;
        if (o_stalled !== 1'b1 || o_period_valid !== 1'b0 || o_half_period !== '0) begin
          errors++;
          $display("FAIL stall_flag j=%0d got stalled=%b valid=%b hp=%0d exp stalled=1 valid=0 hp=0",
                   j, o_stalled, o_period_valid, o_half_period);
        end
      end
      if (j == 52) begin
        checks++;
        if (o_rise !== 1'b1 || o_stalled !== 1'b0 || o_period_valid !== 1'b0 || o_half_period !== '0) begin
          errors++;
          $display("FAIL stall_recover_arm j=%0d got rise=%b stalled=%b valid=%b hp=%0d exp rise=1 stalled=0 valid=0 hp=0",
                   j, o_rise, o_stalled, o_period_valid, o_half_period);
        end
      end
      if (j == 57) begin
        checks++;
        if (o_fall !== 1'b1 || o_stalled !== 1'b0 || o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(5)) begin
          errors++;
          $display("FAIL stall_recover_capture j=%0d got fall=%b stalled=%b valid=%b hp=%0d exp fall=1 stalled=0 valid=1 hp=5",
                   j, o_fall, o_stalled, o_period_valid, o_half_period);
        end
      end
    end
  endtask

  // Half period 20 captures exactly TIMEOUT; half period 21 stalls then re-arms.
  task automatic test_edge_on_timeout();
    do_reset();
    for (int j = 0; j < 70; j++) begin
      i_tick_clk = ((j / 20) % 2 == 0);
      step();
      checks++;
      if (o_stalled !== 1'b0) begin
        errors++;
        $display("FAIL tmo20_no_stall j=%0d got=%b exp=0", j, o_stalled);
      end
      if (j == 22 || j == 42 || j == 62) begin
        checks++;
        if ((o_rise | o_fall) !== 1'b1 || o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(20)) begin
          errors++;
          $display("FAIL tmo20_capture j=%0d got rise=%b fall=%b valid=%b hp=%0d exp strobe valid=1 hp=20",
                   j, o_rise, o_fall, o_period_valid, o_half_period);
        end
      end
    end
    do_reset();
    for (int j = 0; j < 31; j++) begin
      i_tick_clk = ((j / 21) % 2 == 0);
      step();
      if (j == 21) begin
        checks++;
        if (o_stalled !== 1'b0) begin
          errors++;
          $display("FAIL tmo21_pre j=%0d got stalled=%b exp 0", j, o_stalled);
        end
      end
      if (j == 22) begin
        checks++;
        if (o_stalled !== 1'b1 || o_period_valid !== 1'b0 || o_half_period !== '0) begin
          errors++;
          $display("FAIL tmo21_stall j=%0d got stalled=%b valid=%b hp=%0d exp stalled=1 valid=0 hp=0",
                   j, o_stalled, o_period_valid, o_half_period);
        end
      end
      if (j == 23) begin
        checks++;
        if (o_fall !== 1'b1 || o_stalled !== 1'b0 || o_period_valid !== 1'b0 || o_half_period !== '0) begin
          errors++;
          $display("FAIL tmo21_clear j=%0d got fall=%b stalled=%b valid=%b hp=%0d exp fall=1 stalled=0 valid=0 hp=0",
                   j, o_fall, o_stalled, o_period_valid, o_half_period);
        end
      end
    end
  endtask

  // Reset pulse in the low phase right after the first capture.
  task automatic test_reset_mid();
    do_reset();
    for (int j = 0; j < 20; j++) begin
      i_tick_clk = ((j / 5) % 2 == 0);
      step();
      if (j == 7) begin
        checks++;
        if (o_fall !== 1'b1 || o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(5)) begin
          errors++;
          $display("FAIL mid_pre j=%0d got fall=%b valid=%b hp=%0d exp fall=1 valid=1 hp=5",
                   j, o_fall, o_period_valid, o_half_period);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin
          errors++;
          $display("FAIL mid_async_clear got=%h exp=0", outs);
        end
      end
      if (j == 8) begin
        checks++;
        if (outs !== '0) begin
          errors++;
          $display("FAIL mid_held got=%h exp=0", outs);
        end
        i_rst_n = 1'b1;
      end
      if (j == 12 || j == 16) begin
        checks++;
        if (o_rise !== (j == 12) || o_period_valid !== 1'b0) begin
          errors++;
          $display("FAIL mid_arm_only j=%0d got rise=%b valid=%b exp rise=%b valid=0", j, o_rise, o_period_valid, (j == 12));
        end
      end
      if (j == 17) begin
        checks++;
        if (o_fall !== 1'b1 || o_period_valid !== 1'b1 || o_half_period !== (CW+1)'(5)) begin
          errors++;
          $display("FAIL mid_capture j=%0d got fall=%b valid=%b hp=%0d exp fall=1 valid=1 hp=5",
                   j, o_fall, o_period_valid, o_half_period);
        end
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    i_rst_n    = 1'b0;
    i_tick_clk = 1'b0;
    test_reset();
    test_symmetric();
    test_asymmetric();
    test_stall();
    test_edge_on_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
